// File: rtl/qs_pkg.sv
// Shared types and constants for the quicksort engine bank scheduler.
package qs_pkg;

  localparam int BANK_N    = 2;
  localparam int BANK_ID_W = $clog2(BANK_N);

  typedef logic [BANK_ID_W-1:0] bank_id_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    READY  = 3'd2,
    SORT   = 3'd3,
    SORTED = 3'd4,
    DRAIN  = 3'd5
  } bank_sched_state_t;

  // Stage index: 0 = enq, 1 = srt, 2 = deq.
  function automatic bank_sched_state_t stage_pre(input int s);
    case (s)
      0:       return IDLE;
      1:       return READY;
      default: return SORTED;
    endcase
  endfunction

  function automatic bank_sched_state_t stage_own(input int s);
    case (s)
      0:       return FILL;
      1:       return SORT;
      default: return DRAIN;
    endcase
  endfunction

  function automatic bank_sched_state_t stage_post(input int s);
    case (s)
      0:       return READY;
      1:       return SORTED;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic state_valid(input logic [2:0] st);
    return st <= 3'(DRAIN);
  endfunction

endpackage

// File: rtl/qs_bank_sched_ptr.sv
// Wrap-around bank index counter; advances by one per adv_i pulse, N-1 wraps to 0.
module qs_bank_sched_ptr #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state is built in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/qs_bank_sched.sv
// Bank scheduler: per-bank lifecycle, enq/srt/deq grant FSMs and sticky error.
// Optional statistics outputs enabled by defining QS_BANK_SCHED_STATS_EN.
module qs_bank_sched #(
  parameter  int BANK_N    = qs_pkg::BANK_N,
  localparam int BANK_ID_W = $clog2(BANK_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_req,
  input  logic                  enq_done,
  output logic                  enq_gnt_r,
  output logic [BANK_ID_W-1:0]  enq_idx_r,
  input  logic                  srt_req,
  input  logic                  srt_done,
  output logic                  srt_gnt_r,
  output logic [BANK_ID_W-1:0]  srt_idx_r,
  input  logic                  deq_req,
  input  logic                  deq_done,
  output logic                  deq_gnt_r,
  output logic [BANK_ID_W-1:0]  deq_idx_r,
  output logic [BANK_N*3-1:0]   bank_state_r,
  output logic                  err_r
`ifdef QS_BANK_SCHED_STATS_EN
  ,
  output logic [31:0]           pkt_cnt_r,
  output logic [BANK_ID_W:0]    occ_r
`endif
);

  import qs_pkg::*;

  localparam logic [0:0] GNT_IDLE = 1'b0;
  localparam logic [0:0] GNT_HOLD = 1'b1;

  logic [2:0]           state_q [BANK_N];
  logic [2:0]           state_d [BANK_N];
  logic [0:0]           fsm_q   [3];
  logic [0:0]           fsm_d   [3];
  logic [BANK_ID_W-1:0] idx_q   [3];
  logic [BANK_ID_W-1:0] idx_d   [3];
  logic [BANK_ID_W-1:0] ptr     [3];
  logic [2:0]           req_v, done_v, adv;
  logic                 err_q, err_d;

  assign req_v  = {deq_req, srt_req, enq_req};
  assign done_v = {deq_done, srt_done, enq_done};

  for (genvar s = 0; s < 3; s++) begin : g_ptr
    qs_bank_sched_ptr #(.N(BANK_N), .W(BANK_ID_W)) u_ptr (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv[s]),
      .ptr_o (ptr[s])
    );
  end

  // Stages always own distinct banks, so their updates to state_d never collide.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    adv     = '0;
    err_d   = err_q;
    for (int b = 0; b < BANK_N; b++) begin
      if (!state_valid(state_q[b])) begin
        state_d[b] = IDLE;
        err_d      = 1'b1;
      end
    end
    for (int s = 0; s < 3; s++) begin
      if (fsm_q[s] == GNT_HOLD) begin
        if (done_v[s]) begin
          fsm_d[s]            = GNT_IDLE;
          state_d[idx_q[s]]   = stage_post(s);
          adv[s]              = 1'b1;
        end
      end else begin
        if (done_v[s]) err_d = 1'b1;
        if (req_v[s] && state_q[ptr[s]] == stage_pre(s)) begin
          fsm_d[s]          = GNT_HOLD;
          idx_d[s]          = ptr[s];
          state_d[ptr[s]]   = stage_own(s);
        end
      end
    end
  end

  // NOTE: the bank state array is a handful of flops, not a RAM, so every entry is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BANK_N; b++) state_q[b] <= IDLE;
      for (int s = 0; s < 3; s++) begin
        fsm_q[s] <= GNT_IDLE;
        idx_q[s] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  for (genvar b = 0; b < BANK_N; b++) begin : g_state_out
    assign bank_state_r[b*3 +: 3] = state_q[b];
  end

  assign enq_gnt_r = (fsm_q[0] == GNT_HOLD);
  assign srt_gnt_r = (fsm_q[1] == GNT_HOLD);
  assign deq_gnt_r = (fsm_q[2] == GNT_HOLD);
  assign enq_idx_r = idx_q[0];
  assign srt_idx_r = idx_q[1];
  assign deq_idx_r = idx_q[2];
  assign err_r     = err_q;

`ifdef QS_BANK_SCHED_STATS_EN
  logic [31:0]        pkt_cnt_q;
  logic [BANK_ID_W:0] occ_q, occ_d;

  // Occupancy tracks the next bank state so it lines up with bank_state_r.
  always_comb begin
    occ_d = '0;
    for (int b = 0; b < BANK_N; b++) begin
      if (state_d[b] != IDLE) occ_d = occ_d + (BANK_ID_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      occ_q     <= '0;
    end else begin
      if (adv[2] && pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      occ_q <= occ_d;
    end
  end

  assign pkt_cnt_r = pkt_cnt_q;
  assign occ_r     = occ_q;
`endif

endmodule

// File: tb/tb_qs_bank_sched.sv
// Directed self-checking bench for qs_bank_sched: BANK_N=2 and BANK_N=3 instances.
module tb_qs_bank_sched;
  import qs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // BANK_N = 2 instance
  logic       e_req = 0, e_done = 0, s_req = 0, s_done = 0, d_req = 0, d_done = 0;
  logic       e_gnt, s_gnt, d_gnt, err2;
  logic [0:0] e_idx, s_idx, d_idx;
  logic [5:0] bst2;
  // BANK_N = 3 instance
  logic       e3_req = 0, e3_done = 0, s3_req = 0, s3_done = 0, d3_req = 0, d3_done = 0;
  logic       e3_gnt, s3_gnt, d3_gnt, err3;
  logic [1:0] e3_idx, s3_idx, d3_idx;
  logic [8:0] bst3;
`ifdef QS_BANK_SCHED_STATS_EN
  logic [31:0] pkt2, pkt3;
  logic [1:0]  occ2;
  logic [2:0]  occ3;
`endif

  qs_bank_sched #(.BANK_N(2)) dut2 (
    .clk(clk), .rst(rst),
    .enq_req(e_req), .enq_done(e_done), .enq_gnt_r(e_gnt), .enq_idx_r(e_idx),
    .srt_req(s_req), .srt_done(s_done), .srt_gnt_r(s_gnt), .srt_idx_r(s_idx),
    .deq_req(d_req), .deq_done(d_done), .deq_gnt_r(d_gnt), .deq_idx_r(d_idx),
    .bank_state_r(bst2), .err_r(err2)
`ifdef QS_BANK_SCHED_STATS_EN
    , .pkt_cnt_r(pkt2), .occ_r(occ2)
`endif
  );

  qs_bank_sched #(.BANK_N(3)) dut3 (
    .clk(clk), .rst(rst),
    .enq_req(e3_req), .enq_done(e3_done), .enq_gnt_r(e3_gnt), .enq_idx_r(e3_idx),
    .srt_req(s3_req), .srt_done(s3_done), .srt_gnt_r(s3_gnt), .srt_idx_r(s3_idx),
    .deq_req(d3_req), .deq_done(d3_done), .deq_gnt_r(d3_gnt), .deq_idx_r(d3_idx),
    .bank_state_r(bst3), .err_r(err3)
`ifdef QS_BANK_SCHED_STATS_EN
    , .pkt_cnt_r(pkt3), .occ_r(occ3)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] b2(input int i);
    return bst2[i*3 +: 3];
  endfunction

  task automatic do_reset;
    {e_req, e_done, s_req, s_done, d_req, d_done} = '0;
    {e3_req, e3_done, s3_req, s3_done, d3_req, d3_done} = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic enq2(input logic [0:0] exp_idx);
    e_req = 1; tick; e_req = 0;
    n_checks++;
    if (e_gnt !== 1'b1 || e_idx !== exp_idx || b2(exp_idx) !== FILL) begin
      n_fail++;
      $display("FAIL enq_grant: gnt=%0b idx=%0d st=%0d, expected gnt=1 idx=%0d st=%0d",
               e_gnt, e_idx, b2(exp_idx), exp_idx, FILL);
    end
    e_done = 1; tick; e_done = 0;
    n_checks++;
    if (e_gnt !== 1'b0 || b2(exp_idx) !== READY) begin
      n_fail++;
      $display("FAIL enq_done: gnt=%0b st=%0d, expected gnt=0 st=%0d", e_gnt, b2(exp_idx), READY);
    end
  endtask

  task automatic srt2(input logic [0:0] exp_idx);
    s_req = 1; tick; s_req = 0;
    n_checks++;
    if (s_gnt !== 1'b1 || s_idx !== exp_idx || b2(exp_idx) !== SORT) begin
      n_fail++;
      $display("FAIL srt_grant: gnt=%0b idx=%0d st=%0d, expected gnt=1 idx=%0d st=%0d",
               s_gnt, s_idx, b2(exp_idx), exp_idx, SORT);
    end
    s_done = 1; tick; s_done = 0;
    n_checks++;
    if (s_gnt !== 1'b0 || b2(exp_idx) !== SORTED) begin
      n_fail++;
      $display("FAIL srt_done: gnt=%0b st=%0d, expected gnt=0 st=%0d", s_gnt, b2(exp_idx), SORTED);
    end
  endtask

  task automatic deq2(input logic [0:0] exp_idx);
    d_req = 1; tick; d_req = 0;
    n_checks++;
    if (d_gnt !== 1'b1 || d_idx !== exp_idx || b2(exp_idx) !== DRAIN) begin
      n_fail++;
      $display("FAIL deq_grant: gnt=%0b idx=%0d st=%0d, expected gnt=1 idx=%0d st=%0d",
               d_gnt, d_idx, b2(exp_idx), exp_idx, DRAIN);
    end
    d_done = 1; tick; d_done = 0;
    n_checks++;
    if (d_gnt !== 1'b0 || b2(exp_idx) !== IDLE) begin
      n_fail++;
      $display("FAIL deq_done: gnt=%0b st=%0d, expected gnt=0 st=%0d", d_gnt, b2(exp_idx), IDLE);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    n_checks++;
    if ({e_gnt, s_gnt, d_gnt, err2, e_idx, s_idx, d_idx} !== 7'b0 || bst2 !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_n2: gnt=%b err=%b idx=%b%b%b banks=%b, expected all 0",
               {e_gnt, s_gnt, d_gnt}, err2, e_idx, s_idx, d_idx, bst2);
    end
    n_checks++;
    if ({e3_gnt, s3_gnt, d3_gnt, err3, e3_idx, s3_idx, d3_idx} !== 10'b0 || bst3 !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_n3: gnt=%b err=%b banks=%b, expected all 0",
               {e3_gnt, s3_gnt, d3_gnt}, err3, bst3);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_packet;
    do_reset;
    enq2(0); srt2(0); deq2(0);
    // Second packet proves every pointer moved to 1.
    enq2(1); srt2(1); deq2(1);
    n_checks++;
    if (err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_err: err=%0b, expected 0", err2);
    end
`ifdef QS_BANK_SCHED_STATS_EN
    n_checks++;
    if (pkt2 !== 32'd2 || occ2 !== 2'd0) begin
      n_fail++;
      $display("FAIL single_stats: pkt=%0d occ=%0d, expected pkt=2 occ=0", pkt2, occ2);
    end
`endif
  endtask

  task automatic test_full;
    do_reset;
    enq2(0); enq2(1);
    e_req = 1;
    repeat (3) tick;
    n_checks++;
    if (e_gnt !== 1'b0 || err2 !== 1'b0 || bst2 !== {3'(READY), 3'(READY)}) begin
      n_fail++;
      $display("FAIL full_wait: gnt=%0b err=%0b banks=%b, expected gnt=0 err=0 banks=010010",
               e_gnt, err2, bst2);
    end
    srt2(0);
    deq2(0);
    n_checks++;
    if (e_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL full_still_wait: gnt=%0b, expected 0", e_gnt);
    end
    tick;
    n_checks++;
    if (e_gnt !== 1'b1 || e_idx !== 1'b0 || b2(0) !== FILL) begin
      n_fail++;
      $display("FAIL full_regrant: gnt=%0b idx=%0d st=%0d, expected gnt=1 idx=0 st=%0d",
               e_gnt, e_idx, b2(0), FILL);
    end
    e_req = 0; e_done = 1; tick; e_done = 0;
  endtask

  task automatic test_overlap;
    do_reset;
    enq2(0);
    e_req = 1; s_req = 1; tick; e_req = 0;
    n_checks++;
    if (e_gnt !== 1'b1 || e_idx !== 1'b1 || s_gnt !== 1'b1 || s_idx !== 1'b0 ||
        bst2 !== {3'(FILL), 3'(SORT)}) begin
      n_fail++;
      $display("FAIL overlap_setup: egnt=%0b eidx=%0d sgnt=%0b sidx=%0d banks=%b",
               e_gnt, e_idx, s_gnt, s_idx, bst2);
    end
    // srt_req stays high while held: it must not re-grant until after done.
    e_done = 1; s_done = 1; d_req = 1; tick; e_done = 0; s_done = 0;
    n_checks++;
    if (b2(1) !== READY || b2(0) !== SORTED || {e_gnt, s_gnt, d_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL overlap_t1: b1=%0d b0=%0d gnt=%b, expected b1=%0d b0=%0d gnt=000",
               b2(1), b2(0), {e_gnt, s_gnt, d_gnt}, READY, SORTED);
    end
    tick; s_req = 0; d_req = 0;
    n_checks++;
    if (s_gnt !== 1'b1 || s_idx !== 1'b1 || d_gnt !== 1'b1 || d_idx !== 1'b0 ||
        b2(1) !== SORT || b2(0) !== DRAIN) begin
      n_fail++;
      $display("FAIL overlap_t2: sgnt=%0b sidx=%0d dgnt=%0b didx=%0d banks=%b",
               s_gnt, s_idx, d_gnt, d_idx, bst2);
    end
`ifdef QS_BANK_SCHED_STATS_EN
    n_checks++;
    if (occ2 !== 2'd2) begin
      n_fail++;
      $display("FAIL overlap_occ: occ=%0d, expected 2", occ2);
    end
`endif
  endtask

  task automatic test_error;
    do_reset;
    enq2(0);
    s_done = 1; tick; s_done = 0;
    n_checks++;
    if (err2 !== 1'b1 || s_gnt !== 1'b0 || bst2 !== {3'(IDLE), 3'(READY)}) begin
      n_fail++;
      $display("FAIL err_set: err=%0b sgnt=%0b banks=%b, expected err=1 sgnt=0 banks=000010",
               err2, s_gnt, bst2);
    end
    tick;
    n_checks++;
    if (err2 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%0b, expected 1", err2);
    end
    s_req = 1; tick; s_req = 0;
    n_checks++;
    if (s_gnt !== 1'b1 || s_idx !== 1'b0 || b2(0) !== SORT || err2 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_no_ptr_move: sgnt=%0b sidx=%0d st=%0d err=%0b, expected 1 0 %0d 1",
               s_gnt, s_idx, b2(0), err2, SORT);
    end
  endtask

  // Runs straight after test_error so err_r and a held srt grant are live.
  task automatic test_reset_mid;
    e_req = 1; tick;
    n_checks++;
    if (e_gnt !== 1'b1 || e_idx !== 1'b1 || b2(1) !== FILL) begin
      n_fail++;
      $display("FAIL mid_setup: gnt=%0b idx=%0d st=%0d, expected gnt=1 idx=1 st=%0d",
               e_gnt, e_idx, b2(1), FILL);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({e_gnt, s_gnt, d_gnt} !== 3'b000 || bst2 !== 6'b0 || err2 !== 1'b0 || e_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: gnt=%b banks=%b err=%0b eidx=%0d, expected all 0",
               {e_gnt, s_gnt, d_gnt}, bst2, err2, e_idx);
    end
`ifdef QS_BANK_SCHED_STATS_EN
    n_checks++;
    if (pkt2 !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_pkt: pkt=%0d, expected 0", pkt2);
    end
`endif
    e_req = 0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_wrap;
    logic [1:0] exp_idx;
    do_reset;
    for (int p = 0; p < 7; p++) begin
      exp_idx = 2'(p % 3);
      e3_req = 1; tick; e3_req = 0;
      n_checks++;
      if (e3_gnt !== 1'b1 || e3_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL wrap_enq[%0d]: gnt=%0b idx=%0d, expected gnt=1 idx=%0d", p, e3_gnt, e3_idx, exp_idx);
      end
      e3_done = 1; tick; e3_done = 0;
      s3_req = 1; tick; s3_req = 0;
      n_checks++;
      if (s3_gnt !== 1'b1 || s3_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL wrap_srt[%0d]: gnt=%0b idx=%0d, expected gnt=1 idx=%0d", p, s3_gnt, s3_idx, exp_idx);
      end
      s3_done = 1; tick; s3_done = 0;
      d3_req = 1; tick; d3_req = 0;
      n_checks++;
      if (d3_gnt !== 1'b1 || d3_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL wrap_deq[%0d]: gnt=%0b idx=%0d, expected gnt=1 idx=%0d", p, d3_gnt, d3_idx, exp_idx);
      end
      d3_done = 1; tick; d3_done = 0;
    end
    n_checks++;
    if (err3 !== 1'b0 || bst3 !== 9'b0) begin
      n_fail++;
      $display("FAIL wrap_end: err=%0b banks=%b, expected err=0 banks=0", err3, bst3);
    end
`ifdef QS_BANK_SCHED_STATS_EN
    n_checks++;
    if (pkt3 !== 32'd7) begin
      n_fail++;
      $display("FAIL wrap_pkt: pkt=%0d, expected 7", pkt3);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_single_packet;
    test_full;
    test_overlap;
    test_error;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
